// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM region reader: FSM state encoding and
// default window base / outstanding-read limit.
package sdram_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [25:0] BASE_ADDR_DEFAULT = 26'h2000000;
    localparam int          MAX_OUT_DEFAULT   = 4;

endpackage

// File: rtl/sdram_region_reader_if.sv
// Avalon-MM read master bus between the region reader and the SDRAM
// controller. Write lines exist for bus compatibility and are driven to 0.
interface sdram_region_reader_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic              master_write;
    logic [DATA_W-1:0] master_writedata;
    logic [DATA_W-1:0] master_readdata;
    logic              master_readdatavalid;
    logic              master_waitrequest;

    modport master (
        output master_address, master_read, master_write, master_writedata,
        input  master_readdata, master_readdatavalid, master_waitrequest
    );

    modport slave (
        input  master_address, master_read, master_write, master_writedata,
        output master_readdata, master_readdatavalid, master_waitrequest
    );
endinterface

// File: rtl/sdram_rd_credit.sv
// Outstanding-read counter. Simultaneous inc and dec cancel; dec on an
// empty counter is dropped so a stray return can never wrap the count.
module sdram_rd_credit #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);
    logic [CNT_W-1:0] count;

    // Track reads accepted by the bus but not yet returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CNT_W'(1);
        end else if (!inc && dec && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign full  = (count >= CNT_W'(MAX_OUT));
    assign empty = (count == '0);
endmodule

// File: rtl/sdram_region_reader.sv
// Reads a byte region of the SDRAM window over an Avalon-MM master and
// streams the returned bytes out with their 0-based index.
// Optional feature macro: SDRAM_READER_CHECKSUM_EN adds a 16-bit running
// sum of the streamed bytes on port checksum.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// ISSUE   | issuing reads while credits and length allow
// DRAIN   | all reads issued (or aborted), waiting for returns
// DONE    | one-cycle completion, done pulses on the following cycle
module sdram_region_reader
    import sdram_pkg::*;
#(
    parameter int                ADDR_W    = 26,
    parameter int                DATA_W    = 8,
    parameter int                LEN_W     = 12,
    parameter int                MAX_OUT   = MAX_OUT_DEFAULT,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LEN_W-1:0]  req_offset,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              abort,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_index,
    output logic              done,
    output logic              aborted,
    output logic              busy,
    sdram_region_reader_if.master m
`ifdef SDRAM_READER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q, issued_q, received_q;
    logic              abort_q;
    logic              rd_req, rd_accept, rd_return;
    logic              cr_full, cr_empty;

    assign rd_accept = rd_req && !m.master_waitrequest;
    assign rd_return = m.master_readdatavalid && (state_q == S_ISSUE || state_q == S_DRAIN);

    assign m.master_read      = rd_req;
    assign m.master_address   = addr_q;
    assign m.master_write     = 1'b0;
    assign m.master_writedata = '0;
    assign req_ready          = (state_q == S_IDLE);
    assign busy               = (state_q != S_IDLE);

    sdram_rd_credit #(.MAX_OUT(MAX_OUT)) u_credit (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_accept),
        .dec   (rd_return),
        .full  (cr_full),
        .empty (cr_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and read request; abort gates the request in its own cycle.
    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = (req_len == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                rd_req = !abort && (issued_q < len_q) && !cr_full;
                if (abort) begin
                    state_d = S_DRAIN;
                end else if (rd_req && !m.master_waitrequest &&
                             (issued_q + LEN_W'(1) == len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cr_empty && (abort_q || abort || received_q == len_q)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, address/count bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            abort_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            if (state_q == S_IDLE && req_valid) begin
                addr_q     <= BASE_ADDR + ADDR_W'(req_offset);
                len_q      <= req_len;
                issued_q   <= '0;
                received_q <= '0;
                abort_q    <= 1'b0;
            end
            if (rd_accept) begin
                addr_q   <= addr_q + ADDR_W'(1);
                issued_q <= issued_q + LEN_W'(1);
            end
            if ((state_q == S_ISSUE || state_q == S_DRAIN) && abort) abort_q <= 1'b1;
            if (rd_return && !abort_q && !abort) begin
                out_valid  <= 1'b1;
                out_data   <= m.master_readdata;
                out_index  <= received_q;
                received_q <= received_q + LEN_W'(1);
            end
            if (state_q == S_DONE) begin
                done    <= 1'b1;
                aborted <= abort_q;
            end
        end
    end

`ifdef SDRAM_READER_CHECKSUM_EN
    // Running 16-bit sum of streamed bytes, restarted on each accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (state_q == S_IDLE && req_valid) begin
            checksum <= '0;
        end else if (out_valid) begin
            checksum <= checksum + 16'(out_data);
        end
    end
`endif
endmodule

// File: tb/tb_sdram_region_reader.sv
// Directed bench for sdram_region_reader with a behavioural Avalon slave
// (fixed read latency, optional waitrequest stall window).
module tb_sdram_region_reader;
    import sdram_pkg::*;

    localparam int          ADDR_W = 26;
    localparam int          DATA_W = 8;
    localparam int          LEN_W  = 12;
    localparam logic [25:0] BASE   = 26'h2000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              req_valid, req_ready, abort;
    logic [LEN_W-1:0]  req_offset, req_len, out_index;
    logic              out_valid, done, aborted, busy;
    logic [DATA_W-1:0] out_data;
`ifdef SDRAM_READER_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    sdram_region_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_region_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUT(4), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_offset(req_offset), .req_len(req_len), .abort(abort),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .done(done), .aborted(aborted), .busy(busy),
        .m(bus)
`ifdef SDRAM_READER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model state
    logic [7:0]  mem [16];
    int          lat = 2;
    int          due_q[$];
    logic [25:0] adr_q[$];
    logic [25:0] acc_log[$];
    int          n_acc, n_ret, max_pend, ret_cyc, read_cycles, want;
    int          stall_at, stall_left, stall_seen;
    logic [25:0] stall_exp;
    bit          stall_bad, throttled;

    // Monitor state
    logic [7:0]       ov_data[$];
    logic [LEN_W-1:0] ov_idx[$];
    int               done_cnt, done_cyc, last_ov_cyc, acc_cyc;
    logic             done_ab;
    logic [15:0]      cks_at_done;

    function automatic logic [7:0] exp_byte(input int a);
        return 8'hA0 + 8'(a & 15);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = exp_byte(i);
        bus.master_readdata      = '0;
        bus.master_readdatavalid = 1'b0;
        bus.master_waitrequest   = 1'b0;
    end

    // Avalon slave: samples the settled request just after the falling edge.
    always @(negedge clk) begin
        #1;
        bus.master_readdatavalid = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            bus.master_readdatavalid = 1'b1;
            bus.master_readdata      = mem[adr_q[0][3:0]];
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
            n_ret++;
            ret_cyc = cyc;
        end
        bus.master_waitrequest = 1'b0;
        if (stall_left > 0 && n_acc == stall_at && bus.master_read) begin
            bus.master_waitrequest = 1'b1;
            stall_left--;
            stall_seen++;
            if (bus.master_address !== stall_exp) stall_bad = 1'b1;
        end
        if (busy && !bus.master_read && n_acc < want && !abort) throttled = 1'b1;
        if (bus.master_read) read_cycles++;
        if (bus.master_read && !bus.master_waitrequest) begin
            n_acc++;
            acc_log.push_back(bus.master_address);
            due_q.push_back(cyc + lat);
            adr_q.push_back(bus.master_address);
        end
        if (n_acc - n_ret > max_pend) max_pend = n_acc - n_ret;
    end

    // Output monitor.
    always @(negedge clk) begin
        if (out_valid) begin
            ov_data.push_back(out_data);
            ov_idx.push_back(out_index);
            last_ov_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_ab  = aborted;
`ifdef SDRAM_READER_CHECKSUM_EN
            cks_at_done = checksum;
`endif
        end
    end

    task automatic clear_log();
        acc_log.delete(); ov_data.delete(); ov_idx.delete();
        n_acc = 0; n_ret = 0; max_pend = 0; read_cycles = 0; want = 0;
        stall_at = 0; stall_left = 0; stall_seen = 0; stall_bad = 1'b0; throttled = 1'b0;
        done_cnt = 0; done_cyc = 0; last_ov_cyc = 0; done_ab = 1'b0; ret_cyc = 0;
    endtask

    task automatic start(input int off, input int len);
        @(negedge clk);
        req_offset = LEN_W'(off);
        req_len    = LEN_W'(len);
        req_valid  = 1'b1;
        acc_cyc    = cyc;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic check_stream(input string name, input int off, input int len);
        checks++;
        if (ov_data.size() !== len)
            begin errors++; $display("FAIL %s_count: got %0d outputs, expected %0d", name, ov_data.size(), len); end
        for (int i = 0; i < len && i < ov_data.size(); i++) begin
            checks++;
            if (ov_data[i] !== exp_byte(off + i) || ov_idx[i] !== LEN_W'(i)) begin
                errors++;
                $display("FAIL %s_data[%0d]: got data %h index %0d, expected %h index %0d",
                         name, i, ov_data[i], ov_idx[i], exp_byte(off + i), i);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if ({req_ready, busy, out_valid, done, aborted, bus.master_read, bus.master_write} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_flags: got rdy=%b busy=%b ov=%b done=%b ab=%b rd=%b wr=%b, expected 1,0,0,0,0,0,0",
                     req_ready, busy, out_valid, done, aborted, bus.master_read, bus.master_write);
        end
        checks++;
        if (out_data !== 8'h00 || out_index !== 12'h000) begin
            errors++; $display("FAIL reset_outs: got data %h index %h, expected 0", out_data, out_index);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        clear_log(); lat = 2;
        start(0, 4);
        wait_done("basic", 100);
        checks++;
        if (acc_log.size() !== 4) begin errors++; $display("FAIL basic_reads: got %0d, expected 4", acc_log.size()); end
        for (int i = 0; i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i] !== BASE + 26'(i)) begin
                errors++; $display("FAIL basic_addr[%0d]: got %h, expected %h", i, acc_log[i], BASE + 26'(i));
            end
        end
        check_stream("basic", 0, 4);
        checks++;
        if (done_cnt !== 1 || done_ab !== 1'b0 || done_cyc <= last_ov_cyc) begin
            errors++;
            $display("FAIL basic_done: got pulses %0d aborted %b done@%0d last_out@%0d, expected 1 pulse, aborted 0, after last out",
                     done_cnt, done_ab, done_cyc, last_ov_cyc);
        end
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got rdy=%b busy=%b, expected 1,0", req_ready, busy);
        end
    endtask

    task automatic test_outstanding();
        clear_log(); lat = 10; want = 8;
        start(0, 8);
        wait_done("outstanding", 200);
        checks++;
        if (max_pend !== 4) begin errors++; $display("FAIL outstanding_max: got %0d, expected 4", max_pend); end
        checks++;
        if (throttled !== 1'b1) begin errors++; $display("FAIL outstanding_throttle: got %b, expected 1", throttled); end
        check_stream("outstanding", 0, 8);
        checks++;
        if (done_ab !== 1'b0) begin errors++; $display("FAIL outstanding_aborted: got %b, expected 0", done_ab); end
    endtask

    task automatic test_waitrequest();
        clear_log(); lat = 2;
        stall_at = 2; stall_left = 3; stall_exp = BASE + 26'd12;
        start(10, 6);
        wait_done("waitreq", 100);
        checks++;
        if (stall_seen !== 3 || stall_bad !== 1'b0) begin
            errors++; $display("FAIL waitreq_hold: got stalls %0d bad %b, expected 3, 0", stall_seen, stall_bad);
        end
        checks++;
        if (acc_log.size() !== 6) begin errors++; $display("FAIL waitreq_reads: got %0d, expected 6", acc_log.size()); end
        for (int i = 0; i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i] !== BASE + 26'(10 + i)) begin
                errors++; $display("FAIL waitreq_addr[%0d]: got %h, expected %h", i, acc_log[i], BASE + 26'(10 + i));
            end
        end
        check_stream("waitreq", 10, 6);
    endtask

    task automatic test_zero_len();
        clear_log(); lat = 2;
        start(5, 0);
        wait_done("zerolen", 20);
        checks++;
        if (done_cyc - acc_cyc !== 2) begin
            errors++; $display("FAIL zerolen_latency: got %0d cycles, expected 2", done_cyc - acc_cyc);
        end
        checks++;
        if (read_cycles !== 0 || done_cnt !== 1 || done_ab !== 1'b0 || ov_data.size() !== 0) begin
            errors++;
            $display("FAIL zerolen_quiet: got reads %0d pulses %0d aborted %b outs %0d, expected 0,1,0,0",
                     read_cycles, done_cnt, done_ab, ov_data.size());
        end
    endtask

    task automatic test_abort();
        int n = 0;
        clear_log(); lat = 2;
        start(0, 10);
        while (n_acc != 3 && n < 50) begin @(negedge clk); n++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort", 100);
        checks++;
        if (n_acc !== 3 || n_ret !== 3) begin
            errors++; $display("FAIL abort_reads: got issued %0d returned %0d, expected 3, 3", n_acc, n_ret);
        end
        check_stream("abort", 0, 1);
        checks++;
        if (done_cnt !== 1 || done_ab !== 1'b1 || done_cyc <= ret_cyc) begin
            errors++;
            $display("FAIL abort_done: got pulses %0d aborted %b done@%0d last_ret@%0d, expected 1, 1, after last return",
                     done_cnt, done_ab, done_cyc, ret_cyc);
        end
    endtask

    task automatic test_abort_idle();
        clear_log();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done_cnt !== 0) begin
            errors++; $display("FAIL abort_idle: got rdy=%b busy=%b pulses %0d, expected 1,0,0", req_ready, busy, done_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        clear_log(); lat = 10;
        start(0, 8);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (ov_data.size() !== 0 || done_cnt !== 0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_inflight: got outs %0d pulses %0d busy %b rdy %b, expected 0,0,0,1",
                     ov_data.size(), done_cnt, busy, req_ready);
        end
    endtask

`ifdef SDRAM_READER_CHECKSUM_EN
    task automatic test_checksum();
        clear_log(); lat = 2;
        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h02;
        start(0, 3);
        wait_done("checksum", 100);
        checks++;
        if (cks_at_done !== 16'h0200) begin
            errors++; $display("FAIL checksum_value: got %h, expected 0200", cks_at_done);
        end
        for (int i = 0; i < 3; i++) mem[i] = exp_byte(i);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; abort = 1'b0;
        req_offset = '0; req_len = '0;
        clear_log();
        test_reset();
        test_basic();
        test_outstanding();
        test_waitrequest();
        test_zero_len();
        test_abort();
        test_abort_idle();
        test_reset_midflight();
`ifdef SDRAM_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
